// File: rtl/datapath_pkg.sv
// Shared definitions for the operand-fetch datapath: widths, shift codes,
// fetch FSM encoding and the latched request record.
package datapath_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  typedef logic [1:0] shift_t;

  localparam shift_t SH_NONE = 2'b00;
  localparam shift_t SH_LSL  = 2'b01;
  localparam shift_t SH_LSR  = 2'b10;
  localparam shift_t SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    READ_A = 2'b01,
    READ_B = 2'b10,
    DONE   = 2'b11
  } state_t;

  // Request captured when a fetch is accepted; held until the next accept.
  typedef struct packed {
    logic [AW-1:0] rn;
    logic [AW-1:0] rm;
    shift_t        sh;
  } fetch_req_t;

  function automatic fetch_req_t make_req(input logic [AW-1:0] rn,
                                          input logic [AW-1:0] rm,
                                          input shift_t sh);
    fetch_req_t r;
    r.rn = rn;
    r.rm = rm;
    r.sh = sh;
    return r;
  endfunction

endpackage

// File: rtl/regfile8x16.sv
// 8 x 16-bit register file: one synchronous write port, one combinational
// read port with same-cycle write-to-read bypass. Cleared by async reset.
module regfile8x16
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] readnum,
  output logic [DW-1:0] data_out
);

  logic [NREG-1:0][DW-1:0] regs;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [DW-1:0] q_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q_reg <= '0;
        end else if (write && (writenum == AW'(gi))) begin
          q_reg <= data_in;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  // A write landing on the register being read this cycle wins over the stored value.
  assign data_out = (write && (writenum == readnum)) ? data_in : regs[readnum];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads Rn then Rm through a single read port and
// presents A/B plus the shift code to the ALU/shifter under valid/ack.
module operand_fetch
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [DW-1:0] data_in,
  input  logic          start,
  input  logic [AW-1:0] rn,
  input  logic [AW-1:0] rm,
  input  logic [1:0]    shift_in,
  input  logic          ack,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [1:0]    shift_out,
  output logic          valid,
  output logic          busy
);

  state_t        state_reg;
  fetch_req_t    req_reg;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] rd_data;

  // The read port follows the FSM: Rm during READ_B, Rn otherwise.
  always_comb begin
    rd_idx = req_reg.rn;
    if (state_reg == READ_B) begin
      rd_idx = req_reg.rm;
    end
  end

  regfile8x16 u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .write    (write),
    .writenum (writenum),
    .data_in  (data_in),
    .readnum  (rd_idx),
    .data_out (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      req_reg   <= make_req('0, '0, SH_NONE);
      a_out     <= '0;
      b_out     <= '0;
      shift_out <= SH_NONE;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            req_reg   <= make_req(rn, rm, shift_in);
            state_reg <= READ_A;
            busy      <= 1'b1;
          end
        end
        READ_A: begin
          a_out     <= rd_data;
          state_reg <= READ_B;
        end
        READ_B: begin
          b_out     <= rd_data;
          shift_out <= req_reg.sh;
          state_reg <= DONE;
          busy      <= 1'b0;
          valid     <= 1'b1;
        end
        DONE: begin
          // Outputs stay frozen until the consumer acks; start is ignored until then.
          if (ack) begin
            valid <= 1'b0;
            if (start) begin
              req_reg   <= make_req(rn, rm, shift_in);
              state_reg <= READ_A;
              busy      <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          valid     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, hand-written
// corner sequences, and randomized fetches checked against a register-array model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        start;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [1:0]  shift_in;
  logic        ack;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [1:0]  shift_out;
  logic        valid;
  logic        busy;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .start     (start),
    .rn        (rn),
    .rm        (rm),
    .shift_in  (shift_in),
    .ack       (ack),
    .a_out     (a_out),
    .b_out     (b_out),
    .shift_out (shift_out),
    .valid     (valid),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] mem [8];

  typedef struct {
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic        wa;
    logic [2:0]  wna;
    logic [15:0] wda;
    logic        wb;
    logic [2:0]  wnb;
    logic [15:0] wdb;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream shifter behaviour, used to confirm the operand/shift pairing.
  function automatic logic [15:0] shifter(input logic [15:0] b, input logic [1:0] code);
    case (code)
      2'b01:   return b << 1;
      2'b10:   return b >> 1;
      2'b11:   return {b[15], b[15:1]};
      default: return b;
    endcase
  endfunction

  // One clock edge; the reference register array absorbs any write at that edge.
  task automatic step();
    logic        w;
    logic [2:0]  wn;
    logic [15:0] d;
    w  = write;
    wn = writenum;
    d  = data_in;
    @(posedge clk);
    #1;
    if (w && reset_n) mem[wn] = d;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    write = 1'b1; writenum = idx; data_in = val;
    step();
    write = 1'b0;
  endtask

  task automatic release_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    $display("ack: valid=%0d busy=%0d", valid, busy);
    check("ack_valid", valid, 1'b0);
    check("ack_busy", busy, 1'b0);
  endtask

  // Issues a fetch from IDLE with optional writes at the READ_A and READ_B edges;
  // returns with the DUT in DONE.
  task automatic fetch(input logic [2:0] frn, input logic [2:0] frm, input logic [1:0] fsh,
                       input logic wa, input logic [2:0] wna, input logic [15:0] wda,
                       input logic wb, input logic [2:0] wnb, input logic [15:0] wdb);
    start = 1'b1; rn = frn; rm = frm; shift_in = fsh; write = 1'b0;
    step();
    start = 1'b0;
    check("ra_busy", busy, 1'b1);
    check("ra_valid", valid, 1'b0);
    write = wa; writenum = wna; data_in = wda;
    step();
    check("rb_busy", busy, 1'b1);
    write = wb; writenum = wnb; data_in = wdb;
    step();
    write = 1'b0;
    $display("fetch rn=%0d rm=%0d sh=%0d -> a=%h b=%h sh=%0d valid=%0d",
             frn, frm, fsh, a_out, b_out, shift_out, valid);
  endtask

  task automatic rand_write();
    write    = 1'($urandom_range(0, 1));
    writenum = 3'($urandom_range(0, 7));
    data_in  = 16'($urandom);
  endtask

  initial begin
    tbl[0] = '{3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h1111, 16'h2222};
    tbl[1] = '{3'd7, 3'd0, 2'b10, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h7777, 16'h0000};
    tbl[2] = '{3'd5, 3'd5, 2'b01, 1'b1, 3'd5, 16'hABCD, 1'b0, 3'd0, 16'h0000, 16'hABCD, 16'hABCD};
    tbl[3] = '{3'd3, 3'd6, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h1234, 16'h3333, 16'h1234};
    tbl[4] = '{3'd4, 3'd4, 2'b00, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0F0F, 16'h4444, 16'h0F0F};
    tbl[5] = '{3'd6, 3'd3, 2'b10, 1'b1, 3'd2, 16'h9999, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'h3333};

    reset_n = 1'b0; write = 1'b0; writenum = '0; data_in = '0;
    start = 1'b0; rn = '0; rm = '0; shift_in = '0; ack = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    step(); step();
    $display("reset: a=%h b=%h sh=%0d valid=%0d busy=%0d", a_out, b_out, shift_out, valid, busy);
    check("rst_a", a_out, 16'h0000);
    check("rst_b", b_out, 16'h0000);
    check("rst_sh", shift_out, 2'b00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    step();

    // Directed vector table over a preloaded register file.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * i));
    for (int i = 0; i < 6; i++) begin
      fetch(tbl[i].rn, tbl[i].rm, tbl[i].sh, tbl[i].wa, tbl[i].wna, tbl[i].wda,
            tbl[i].wb, tbl[i].wnb, tbl[i].wdb);
      check("tbl_valid", valid, 1'b1);
      check("tbl_busy", busy, 1'b0);
      check("tbl_a", a_out, tbl[i].ea);
      check("tbl_b", b_out, tbl[i].eb);
      check("tbl_sh", shift_out, tbl[i].sh);
      release_ack();
    end

    // Reset while in READ_B discards the fetch and clears the register file.
    wr(3'd3, 16'h0005);
    wr(3'd2, 16'h0002);
    start = 1'b1; rn = 3'd3; rm = 3'd2; shift_in = 2'b01;
    step();
    start = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    $display("mid-fetch reset: a=%h b=%h valid=%0d busy=%0d", a_out, b_out, valid, busy);
    check("mrst_valid", valid, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_a", a_out, 16'h0000);
    check("mrst_b", b_out, 16'h0000);
    for (int i = 0; i < 8; i++) mem[i] = '0;
    step();
    reset_n = 1'b1;
    step();
    fetch(3'd3, 3'd2, 2'b00, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    check("mrst_r3", a_out, 16'h0000);
    check("mrst_r2", b_out, 16'h0000);
    release_ack();

    // Basic fetch and downstream shift.
    wr(3'd3, 16'h0005);
    wr(3'd2, 16'h0002);
    fetch(3'd3, 3'd2, 2'b01, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    check("basic_valid", valid, 1'b1);
    check("basic_a", a_out, 16'h0005);
    check("basic_b", b_out, 16'h0002);
    check("basic_sh", shift_out, 2'b01);
    check("basic_shifter", shifter(b_out, shift_out), 16'h0004);

    // Hold in DONE: writes and start must not disturb the presented operands.
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; writenum = 3'd3; data_in = 16'hFFFF;
      start = 1'b1; rn = 3'd0; rm = 3'd0;
      step();
      $display("hold %0d: a=%h valid=%0d busy=%0d", i, a_out, valid, busy);
      check("hold_a", a_out, 16'h0005);
      check("hold_valid", valid, 1'b1);
      check("hold_busy", busy, 1'b0);
    end
    write = 1'b0; start = 1'b0;
    release_ack();
    step();
    check("hold_idle_busy", busy, 1'b0);

    // Bypass on the READ_B edge, arithmetic shift right downstream.
    fetch(3'd1, 3'd4, 2'b11, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'hE000);
    check("byp_a", a_out, 16'h0000);
    check("byp_b", b_out, 16'hE000);
    check("byp_sh", shift_out, 2'b11);
    check("byp_shifter", shifter(b_out, shift_out), 16'hF000);
    release_ack();

    // Back-to-back fetch from DONE, with a start pulse during READ_A ignored.
    fetch(3'd2, 3'd2, 2'b00, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    check("b2b_first_a", a_out, 16'h0002);
    ack = 1'b1; start = 1'b1; rn = 3'd2; rm = 3'd2; shift_in = 2'b10;
    step();
    ack = 1'b0; start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    check("b2b_valid_drop", valid, 1'b0);
    start = 1'b1; rn = 3'd7; rm = 3'd7; shift_in = 2'b01;
    step();
    start = 1'b0;
    step();
    $display("b2b: a=%h b=%h sh=%0d valid=%0d", a_out, b_out, shift_out, valid);
    check("b2b_valid", valid, 1'b1);
    check("b2b_a", a_out, 16'h0002);
    check("b2b_b", b_out, 16'h0002);
    check("b2b_sh", shift_out, 2'b10);
    release_ack();
    step();
    check("b2b_no_extra", busy, 1'b0);

    // Randomized fetches against the register-array model.
    for (int k = 0; k < 150; k++) begin
      logic [2:0]  frn;
      logic [2:0]  frm;
      logic [1:0]  fsh;
      logic [15:0] ea;
      logic [15:0] eb;
      int gap;
      int hold;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rand_write();
        step();
      end
      frn = 3'($urandom_range(0, 7));
      frm = 3'($urandom_range(0, 7));
      fsh = 2'($urandom_range(0, 3));
      start = 1'b1; rn = frn; rm = frm; shift_in = fsh;
      rand_write();
      step();
      start = 1'b0;
      rand_write();
      ea = (write && writenum == frn) ? data_in : mem[frn];
      step();
      rand_write();
      eb = (write && writenum == frm) ? data_in : mem[frm];
      step();
      write = 1'b0;
      $display("rand %0d rn=%0d rm=%0d sh=%0d: a=%h/%h b=%h/%h", k, frn, frm, fsh,
               a_out, ea, b_out, eb);
      check("rnd_valid", valid, 1'b1);
      check("rnd_a", a_out, ea);
      check("rnd_b", b_out, eb);
      check("rnd_sh", shift_out, fsh);
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        rand_write();
        start = 1'($urandom_range(0, 1));
        step();
        check("rnd_hold_a", a_out, ea);
        check("rnd_hold_b", b_out, eb);
        check("rnd_hold_valid", valid, 1'b1);
      end
      write = 1'b0; start = 1'b0;
      release_ack();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
